// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard: per-register outstanding-write counters plus a global total.
// issue_ready is combinational; state and outputs settle one edge after issue/wb. Optional macro: SCOREBOARD_WB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int TOTAL_MAX = 8,
    parameter int TOT_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic             issue_rs1_used,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_rs2_used,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_write,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_mask,
    output logic [TOT_W-1:0] outstanding,
    output logic             error
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [TOT_W-1:0] total_q, total_d;
    logic             error_q, error_d;

    logic             wb_hit, wb_bad, issue_inc;
    logic [CNT_W-1:0] eff_rs1, eff_rs2;
    logic [TOT_W-1:0] eff_total;
    logic             rs1_haz, rs2_haz, rd_blk;

    // x0 is never counted, so a wb to x0 always lands in wb_bad.
    assign wb_hit = wb_valid && (cnt_q[wb_rd] != '0);
    assign wb_bad = wb_valid && !wb_hit;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign eff_rs1   = cnt_q[issue_rs1] - CNT_W'(wb_hit && (wb_rd == issue_rs1));
    assign eff_rs2   = cnt_q[issue_rs2] - CNT_W'(wb_hit && (wb_rd == issue_rs2));
    assign eff_total = total_q - TOT_W'(wb_hit);
`else
    assign eff_rs1   = cnt_q[issue_rs1];
    assign eff_rs2   = cnt_q[issue_rs2];
    assign eff_total = total_q;
`endif

    assign rs1_haz = issue_rs1_used && (issue_rs1 != 5'd0) && (eff_rs1 != '0);
    assign rs2_haz = issue_rs2_used && (issue_rs2 != 5'd0) && (eff_rs2 != '0);
    assign rd_blk  = issue_rd_write && (issue_rd != 5'd0) &&
                     ((cnt_q[issue_rd] == CNT_MAX) || (eff_total == TOT_W'(TOTAL_MAX)));

    assign issue_ready = !flush && !rs1_haz && !rs2_haz && !rd_blk;
    assign issue_inc   = issue_valid && issue_ready && issue_rd_write && (issue_rd != 5'd0);

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (issue_inc && (issue_rd == 5'(r)) && !(wb_hit && (wb_rd == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (wb_hit && (wb_rd == 5'(r)) && !(issue_inc && (issue_rd == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_comb begin
        total_d = total_q;
        if (flush) begin
            total_d = '0;
        end else if (issue_inc && !wb_hit) begin
            total_d = total_q + 1'b1;
        end else if (wb_hit && !issue_inc) begin
            total_d = total_q - 1'b1;
        end
    end

    // A writeback arriving with a flush is discarded, so it cannot flag an error either.
    assign error_d = error_q || (wb_bad && !flush);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            total_q <= '0;
            error_q <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            total_q <= total_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < 32; r++) busy_mask[r] = (cnt_q[r] != '0);
    end

    assign outstanding = total_q;
    assign error       = error_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: drives on the falling edge, checks combinational and registered outputs before the next rising edge.
module tb_regfile_scoreboard;

    logic        clock, reset;
    logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_write;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [3:0]  outstanding;
    logic        error;

    int total_n = 0;
    int bad_n   = 0;

    regfile_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_write (issue_rd_write),
        .issue_ready    (issue_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .busy_mask      (busy_mask),
        .outstanding    (outstanding),
        .error          (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_rd_write = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        idle();
    endtask

    task automatic wr(input logic [4:0] rd);
        issue_valid = 1; issue_rd = rd; issue_rd_write = 1;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd;
    endtask

    initial begin
        idle();
        reset = 0;
        @(negedge clock);
        tick();
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        reset = 1;

        // 1: RAW on x5
        wr(5);
        #1 chk("t1_ready_rd5", 32'(issue_ready), 32'd1);
        tick();
        chk("t1_busy", busy_mask, 32'h0000_0020);
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
        #1 chk("t1_raw_stall", 32'(issue_ready), 32'd0);
        issue_rs1_used = 0;
        #1 chk("t1_rs1_unused", 32'(issue_ready), 32'd1);
        issue_rs1_used = 1;
        wb(5);
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("t1_wb_same_cycle", 32'(issue_ready), 32'd1);
`else
        #1 chk("t1_wb_same_cycle", 32'(issue_ready), 32'd0);
`endif
        tick();
        issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
        #1 chk("t1_ready_after_wb", 32'(issue_ready), 32'd1);
        chk("t1_busy_cleared", busy_mask, 32'h0);
        chk("t1_outstanding_0", 32'(outstanding), 32'd0);
        tick();

        // 2: x0 untracked
        wr(0); issue_rs1 = 0; issue_rs1_used = 1; issue_rs2 = 0; issue_rs2_used = 1;
        #1 chk("t2_ready", 32'(issue_ready), 32'd1);
        tick();
        chk("t2_busy", busy_mask, 32'h0);
        chk("t2_outstanding", 32'(outstanding), 32'd0);

        // 3: per-register saturation on x7
        for (int i = 0; i < 3; i++) begin
            wr(7);
            #1 chk("t3_fill_ready", 32'(issue_ready), 32'd1);
            tick();
        end
        chk("t3_busy", busy_mask, 32'h0000_0080);
        chk("t3_outstanding_3", 32'(outstanding), 32'd3);
        wr(7);
        #1 chk("t3_sat_stall", 32'(issue_ready), 32'd0);
        wb(7);
        #1 chk("t3_sat_stall_wb", 32'(issue_ready), 32'd0);
        tick();
        chk("t3_outstanding_2", 32'(outstanding), 32'd2);
        wr(7); wb(7);
        #1 chk("t3_issue_wb_ready", 32'(issue_ready), 32'd1);
        tick();
        chk("t3_net_unchanged", 32'(outstanding), 32'd2);
        chk("t3_busy_still", busy_mask, 32'h0000_0080);
        wb(7); tick();
        wb(7); tick();
        chk("t3_drained", 32'(outstanding), 32'd0);
        chk("t3_err_clean", 32'(error), 32'd0);

        // 4: global limit
        for (int r = 1; r <= 8; r++) begin
            wr(5'(r));
            tick();
        end
        chk("t4_outstanding_8", 32'(outstanding), 32'd8);
        chk("t4_busy", busy_mask, 32'h0000_01FE);
        wr(9);
        #1 chk("t4_total_stall", 32'(issue_ready), 32'd0);
        issue_rd_write = 0; issue_rs1 = 20; issue_rs1_used = 1;
        #1 chk("t4_nonwrite_ready", 32'(issue_ready), 32'd1);
        idle();
        wb(1); tick();
        chk("t4_outstanding_7", 32'(outstanding), 32'd7);
        wr(9);
        #1 chk("t4_ready_after_wb", 32'(issue_ready), 32'd1);
        tick();
        chk("t4_busy2", busy_mask, 32'h0000_03FC);
        chk("t4_outstanding_8b", 32'(outstanding), 32'd8);

        // 5: flush
        flush = 1; tick();
        chk("t5_pre_flush", 32'(outstanding), 32'd0);
        for (int r = 1; r <= 3; r++) begin
            wr(5'(r));
            tick();
        end
        chk("t5_busy_123", busy_mask, 32'h0000_000E);
        issue_valid = 1; issue_rs2 = 3; issue_rs2_used = 1;
        #1 chk("t5_rs2_stall", 32'(issue_ready), 32'd0);
        idle();
        wr(4); flush = 1;
        #1 chk("t5_flush_ready", 32'(issue_ready), 32'd0);
        tick();
        chk("t5_flush_busy", busy_mask, 32'h0);
        chk("t5_flush_outstanding", 32'(outstanding), 32'd0);

        // 6: sticky error
        wb(12); tick();
        chk("t6_error_set", 32'(error), 32'd1);
        chk("t6_no_count", 32'(outstanding), 32'd0);
        flush = 1; tick();
        chk("t6_error_after_flush", 32'(error), 32'd1);
        wb(0); tick();
        chk("t6_error_still", 32'(error), 32'd1);
        wr(5); tick();
        chk("t6_busy5", busy_mask, 32'h0000_0020);
        // reset beats concurrent issue and wb
        reset = 0; wr(6); wb(5); tick();
        chk("t6_reset_busy", busy_mask, 32'h0);
        chk("t6_reset_outstanding", 32'(outstanding), 32'd0);
        chk("t6_reset_error", 32'(error), 32'd0);
        reset = 1;

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
